// File: rtl/video_pkg.sv
// Shared types and parameter defaults for the video timing / fetch blocks.
package video_pkg;

  localparam int LFS_AW_DEF = 16;
  localparam int LFS_DW_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOST,
    ST_WAIT_FETCH,
    ST_WAIT_HOST
  } lfs_state_t;

endpackage

// File: rtl/edge_detect.sv
// Registers a level and reports its rising/falling edges against the registered copy.
module edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_level <= 1'b0;
    else          r_level <= i_level;
  end

  assign o_rise = i_level & ~r_level;
  assign o_fall = ~i_level & r_level;

endmodule

// File: rtl/line_fetch_scheduler.sv
// Arbitrates one memory port between per-line fetches (in hblank) and host writes.
// Optional LFS_STATS_EN adds underrun_cnt / fetch_cnt statistics outputs.
module line_fetch_scheduler
  import video_pkg::*;
#(
  parameter int AW    = LFS_AW_DEF,
  parameter int DW    = LFS_DW_DEF,
  parameter int WORDS = 4,
  parameter int LINES = 32,
  localparam int WIW  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           hblank,
  input  logic           vblank,
  input  logic [AW-1:0]  base_addr,
  input  logic           host_req,
  input  logic [AW-1:0]  host_addr,
  input  logic [DW-1:0]  host_wdata,
  output logic           host_ack,
  output logic           mem_req,
  output logic           mem_we,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_ack,
  output logic           lb_we,
  output logic [WIW-1:0] lb_addr,
  output logic [DW-1:0]  lb_wdata,
  output logic           underrun
`ifdef LFS_STATS_EN
  ,
  output logic [15:0]    underrun_cnt,
  output logic [15:0]    fetch_cnt
`endif
);

  localparam int LIW = $clog2(LINES + 1);

  lfs_state_t     r_state, w_next_state;
  logic [LIW-1:0] r_line_idx;
  logic [WIW-1:0] r_word_idx;
  logic           r_pend;
  logic           r_stale;
  logic [AW-1:0]  r_fbase;
  logic [AW-1:0]  r_addr;
  logic [DW-1:0]  r_wdata;

  logic w_hb_rise, w_hb_fall, w_vb_rise, w_vb_fall;
  logic w_fetch_start, w_abort, w_rd_done, w_lb_ok, w_last, w_in_fetch;
  logic [AW-1:0] w_line_off, w_fetch_addr;

  edge_detect u_hb_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (hblank),
    .o_rise  (w_hb_rise),
    .o_fall  (w_hb_fall)
  );

  edge_detect u_vb_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .i_level (vblank),
    .o_rise  (w_vb_rise),
    .o_fall  (w_vb_fall)
  );

  assign w_line_off    = AW'(32'(r_line_idx) * 32'(WORDS));
  assign w_fetch_addr  = r_fbase + AW'(r_word_idx);
  assign w_fetch_start = w_hb_rise & ~vblank & (r_line_idx < LIW'(LINES));
  assign w_abort       = w_hb_fall & r_pend;
  assign w_in_fetch    = (r_state == ST_FETCH) || (r_state == ST_WAIT_FETCH);
  assign w_rd_done     = (r_state == ST_WAIT_FETCH) & mem_ack;
  // A read restarted or aborted while in flight is stale: it completes but never lands.
  assign w_lb_ok       = w_rd_done & r_pend & ~r_stale & ~w_abort;
  assign w_last        = (r_word_idx == WIW'(WORDS - 1));
  assign underrun      = w_abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line_idx <= '0;
    end else if (w_vb_fall) begin
      r_line_idx <= '0;
    end else if (w_hb_fall && !vblank && (r_line_idx < LIW'(LINES))) begin
      r_line_idx <= r_line_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend     <= 1'b0;
      r_word_idx <= '0;
      r_fbase    <= '0;
    end else if (w_fetch_start) begin
      r_pend     <= 1'b1;
      r_word_idx <= '0;
      r_fbase    <= base_addr + w_line_off;
    end else if (w_abort) begin
      r_pend     <= 1'b0;
    end else if (w_lb_ok) begin
      if (w_last) r_pend     <= 1'b0;
      else        r_word_idx <= r_word_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stale <= 1'b0;
    end else if (w_rd_done) begin
      r_stale <= 1'b0;
    end else if (w_in_fetch && (w_abort || w_fetch_start)) begin
      r_stale <= 1'b1;
    end
  end

  // Issued address/data are captured so the request stays stable until its ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_FETCH) begin
      r_addr  <= w_fetch_addr;
      r_wdata <= '0;
    end else if (r_state == ST_HOST) begin
      r_addr  <= host_addr;
      r_wdata <= host_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    host_ack     = 1'b0;
    lb_we        = 1'b0;
    lb_addr      = '0;
    lb_wdata     = '0;
    unique case (r_state)
      ST_IDLE: begin
        if ((r_pend && !w_abort) || w_fetch_start) w_next_state = ST_FETCH;
        else if (host_req)                         w_next_state = ST_HOST;
      end
      ST_FETCH: begin
        mem_req      = 1'b1;
        mem_addr     = w_fetch_addr;
        w_next_state = ST_WAIT_FETCH;
      end
      ST_WAIT_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = r_addr;
        if (mem_ack) begin
          lb_we        = w_lb_ok;
          lb_addr      = w_lb_ok ? r_word_idx : '0;
          lb_wdata     = w_lb_ok ? mem_rdata : '0;
          w_next_state = ST_IDLE;
        end
      end
      ST_HOST: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        mem_addr     = host_addr;
        mem_wdata    = host_wdata;
        w_next_state = ST_WAIT_HOST;
      end
      ST_WAIT_HOST: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (mem_ack) begin
          host_ack     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

`ifdef LFS_STATS_EN
  logic [15:0] r_underrun_cnt;
  logic [15:0] r_fetch_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun_cnt <= '0;
      r_fetch_cnt    <= '0;
    end else begin
      if (w_abort && (r_underrun_cnt != 16'hFFFF)) r_underrun_cnt <= r_underrun_cnt + 16'd1;
      if (w_lb_ok && w_last)                       r_fetch_cnt    <= r_fetch_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
  assign fetch_cnt    = r_fetch_cnt;
`endif

  logic w_unused;
  assign w_unused = w_vb_rise;

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Scoreboard bench for line_fetch_scheduler (WORDS=4, LINES=6); honours LFS_STATS_EN.
module tb_line_fetch_scheduler;

  logic        clk = 1'b0;
  logic        reset_n, hblank, vblank, host_req, mem_ack;
  logic [15:0] base_addr, host_addr;
  logic [7:0]  host_wdata, mem_rdata;
  logic        host_ack, mem_req, mem_we, lb_we, underrun;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, lb_wdata;
  logic [1:0]  lb_addr;
`ifdef LFS_STATS_EN
  logic [15:0] underrun_cnt, fetch_cnt;
`endif

  typedef struct packed {logic we; logic [15:0] addr; logic [7:0] wdata;} mem_txn_t;
  typedef struct packed {logic [1:0] addr; logic [7:0] data;} lb_txn_t;

  mem_txn_t    exp_mem[$];
  lb_txn_t     exp_lb[$];
  logic [15:0] exp_host[$];
  int          exp_under[$];
  int n_checks = 0, n_fail = 0;
  int n_lb = 0, n_host = 0, n_under = 0;

  line_fetch_scheduler #(.AW(16), .DW(8), .WORDS(4), .LINES(6)) dut (
    .clk(clk), .reset_n(reset_n), .hblank(hblank), .vblank(vblank),
    .base_addr(base_addr), .host_req(host_req), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .lb_we(lb_we),
    .lb_addr(lb_addr), .lb_wdata(lb_wdata), .underrun(underrun)
`ifdef LFS_STATS_EN
    , .underrun_cnt(underrun_cnt), .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_data(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event, value 0x%0h", name, act);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory responder: acks 3 cycles after a request appears, 1-cycle ack pulse.
  initial begin
    int cnt;
    logic busy;
    mem_ack = 1'b0; mem_rdata = 8'h00; busy = 1'b0; cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        mem_ack = 1'b0; busy = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (!busy && mem_req) begin
        busy = 1'b1; cnt = 3;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          mem_ack = 1'b1; mem_rdata = mem_data(mem_addr); busy = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transaction or strobe.
  initial begin
    logic     prev_req, prev_under;
    mem_txn_t cur, e;
    lb_txn_t  l;
    prev_req = 1'b0; prev_under = 1'b0; cur = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_req = 1'b0; prev_under = 1'b0;
        continue;
      end
      if (mem_req && !prev_req) begin
        if (exp_mem.size() == 0) flag("mem_req_extra", mem_addr);
        else begin
          e = exp_mem.pop_front();
          check("mem_we", mem_we, e.we);
          check("mem_addr", mem_addr, e.addr);
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
        end
        cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
      end
      if (mem_req && mem_ack) begin
        check("mem_hold_addr", mem_addr, cur.addr);
        check("mem_hold_we", mem_we, cur.we);
      end
      if (lb_we) begin
        n_lb++;
        if (exp_lb.size() == 0) flag("lb_we_extra", lb_addr);
        else begin
          l = exp_lb.pop_front();
          check("lb_addr", lb_addr, l.addr);
          check("lb_wdata", lb_wdata, l.data);
        end
      end
      if (host_ack) begin
        n_host++;
        if (exp_host.size() == 0) flag("host_ack_extra", mem_addr);
        else check("host_ack_addr", mem_addr, exp_host.pop_front());
      end
      if (underrun) begin
        n_under++;
        if (prev_under) flag("underrun_width", 2);
        else if (exp_under.size() == 0) flag("underrun_extra", 1);
        else void'(exp_under.pop_front());
      end
      prev_req   = mem_req;
      prev_under = underrun;
    end
  end

  task automatic wait_lb(input int target, input string name);
    int k = 0;
    while (n_lb < target && k < 300) begin tick(1); k++; end
    check(name, n_lb >= target, 1);
  endtask

  task automatic wait_host(input int target, input string name);
    int k = 0;
    while (n_host < target && k < 300) begin tick(1); k++; end
    check(name, n_host >= target, 1);
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!mem_req && k < 100) begin tick(1); k++; end
    check(name, mem_req, 1);
  endtask

  task automatic push_reads(input logic [15:0] first, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = first + 16'(i);
      exp_mem.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
    end
  endtask

  task automatic push_lb(input logic [15:0] first, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = first + 16'(i);
      exp_lb.push_back('{addr: 2'(i), data: mem_data(a)});
    end
  endtask

  task automatic fetch_line(input logic [15:0] base, input logic [15:0] first, input string name);
    int target;
    push_reads(first, 4);
    push_lb(first, 4);
    target = n_lb + 4;
    base_addr = base;
    hblank = 1'b1;
    wait_lb(target, name);
    tick(2);
    hblank = 1'b0;
    tick(3);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_host_ack"}, host_ack, 0);
    check({tag, "_lb_we"}, lb_we, 0);
    check({tag, "_lb_addr"}, lb_addr, 0);
    check({tag, "_lb_wdata"}, lb_wdata, 0);
    check({tag, "_underrun"}, underrun, 0);
  endtask

  initial begin
    reset_n = 1'b0; hblank = 1'b0; vblank = 1'b1; host_req = 1'b0;
    base_addr = 16'h0100; host_addr = 16'h0000; host_wdata = 8'h00;
    tick(2);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    tick(2);

    // hblank pulse during vblank: no fetch, no line advance
    hblank = 1'b1; tick(10); hblank = 1'b0; tick(5);
    vblank = 1'b0; tick(3);

    fetch_line(16'h0100, 16'h0100, "line0_done");
    fetch_line(16'h0100, 16'h0104, "line1_done");

    // Line 2: host write raised mid-fetch must wait for all four reads
    push_reads(16'h0108, 4);
    push_lb(16'h0108, 4);
    exp_mem.push_back('{we: 1'b1, addr: 16'h0040, wdata: 8'h3C});
    exp_host.push_back(16'h0040);
    hblank = 1'b1;
    tick(2);
    host_addr = 16'h0040; host_wdata = 8'h3C; host_req = 1'b1;
    wait_host(1, "line2_host_ack");
    host_req = 1'b0;
    check("line2_lb_count", n_lb, 12);
    tick(2); hblank = 1'b0; tick(3);

    // Line 3: host request and hblank rise in the same cycle; fetch goes first
    push_reads(16'h010C, 4);
    push_lb(16'h010C, 4);
    exp_mem.push_back('{we: 1'b1, addr: 16'h0050, wdata: 8'h77});
    exp_host.push_back(16'h0050);
    host_addr = 16'h0050; host_wdata = 8'h77;
    hblank = 1'b1; host_req = 1'b1;
    wait_host(2, "line3_host_ack");
    host_req = 1'b0;
    check("line3_lb_count", n_lb, 16);
    tick(2); hblank = 1'b0; tick(3);

    // Line 4: hblank falls with the 3rd read outstanding
    push_reads(16'h0110, 3);
    push_lb(16'h0110, 2);
    exp_under.push_back(4);
    hblank = 1'b1;
    wait_lb(18, "line4_two_words");
    wait_req("line4_third_req");
    hblank = 1'b0;
    tick(12);
    check("line4_underrun_seen", n_under, 1);
    check("line4_lb_count", n_lb, 18);

    fetch_line(16'h0100, 16'h0114, "line5_done");

    // Line 6 == LINES: no fetch
    hblank = 1'b1; tick(15); hblank = 1'b0; tick(3);

    // New frame: line index returns to 0
    vblank = 1'b1; tick(4); vblank = 1'b0; tick(2);
    fetch_line(16'h0200, 16'h0200, "frame2_line0_done");

`ifdef LFS_STATS_EN
    check("stats_fetch_cnt", fetch_cnt, 6);
    check("stats_underrun_cnt", underrun_cnt, 1);
`endif

    // Reset while a read is in flight: outputs clear without a clock edge
    push_reads(16'h0304, 1);
    base_addr = 16'h0300;
    hblank = 1'b1;
    wait_req("rst_mid_req");
    tick(1);
    #2 reset_n = 1'b0;
    #1 check_idle_outputs("async_rst");
`ifdef LFS_STATS_EN
    check("rst_fetch_cnt", fetch_cnt, 0);
    check("rst_underrun_cnt", underrun_cnt, 0);
`endif
    hblank = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(6);

    check("end_mem_queue", exp_mem.size(), 0);
    check("end_lb_queue", exp_lb.size(), 0);
    check("end_host_queue", exp_host.size(), 0);
    check("end_under_queue", exp_under.size(), 0);
    check("end_host_count", n_host, 2);
    check("end_under_count", n_under, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
